// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe_if
// Brief    : Operand/result handshake bundle for logic_unit_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] count;

    // Operand source and result consumer side
    modport master (
        output in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        input  in_ready, out_valid, result, zero, parity, count
    );

    // Logic unit side
    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clr, out_ready,
        output in_ready, out_valid, result, zero, parity, count
    );
endinterface
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Registered 8-function bitwise logic unit with valid/ready
//            handshake, accumulator operand, zero/parity flags and counter.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  wire                  clk,
    input  wire                  rst_n,
    logic_unit_pipe_if.slave     bus
);
    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_NAND = 3'b001;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_NOR  = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_XNOR = 3'b101;
    localparam logic [2:0] c_OP_NOTA = 3'b110;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_parity;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_acc;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_res;

    // Single output register: space frees up in the same cycle it is consumed
    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_op_a     = bus.acc_mode ? (bus.acc_clr ? '0 : r_acc) : bus.a;

    always_comb begin
        w_res = w_op_a;
        case (bus.op)
            c_OP_AND:  w_res = w_op_a & bus.b;
            c_OP_NAND: w_res = ~(w_op_a & bus.b);
            c_OP_OR:   w_res = w_op_a | bus.b;
            c_OP_NOR:  w_res = ~(w_op_a | bus.b);
            c_OP_XOR:  w_res = w_op_a ^ bus.b;
            c_OP_XNOR: w_res = ~(w_op_a ^ bus.b);
            c_OP_NOTA: w_res = ~w_op_a;
            default:   w_res = w_op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
        end else if (w_accept) begin
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_parity    <= ^w_res;
            r_out_valid <= 1'b1;
            r_count     <= r_count + CNT_W'(1);
            r_acc       <= w_res;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (bus.acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.parity    = r_parity;
    assign bus.count     = r_count;
endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Brief    : Directed self-checking bench for logic_unit_pipe (CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [CNT_W-1:0] exp_count;

    logic_unit_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic am, input logic ac);
        bus.in_valid = v;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.acc_mode = am;
        bus.acc_clr  = ac;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", bus.result); end
        checks++;
        if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++;
        if ({bus.zero, bus.parity} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus.zero, bus.parity}); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        exp_count = '0;
    endtask

    task automatic test_ops();
        logic [2:0] ops [8];
        logic [7:0] va  [8];
        logic [7:0] vb  [8];
        logic [7:0] er  [8];
        logic       ez  [8];
        logic       ep  [8];
        ops[0]=3'b000; va[0]=8'hF0; vb[0]=8'h3C; er[0]=8'h30; ez[0]=0; ep[0]=0;
        ops[1]=3'b001; va[1]=8'hF0; vb[1]=8'h3C; er[1]=8'hCF; ez[1]=0; ep[1]=0;
        ops[2]=3'b100; va[2]=8'hF0; vb[2]=8'h3C; er[2]=8'hCC; ez[2]=0; ep[2]=0;
        ops[3]=3'b110; va[3]=8'hF0; vb[3]=8'h3C; er[3]=8'h0F; ez[3]=0; ep[3]=0;
        ops[4]=3'b011; va[4]=8'h00; vb[4]=8'h00; er[4]=8'hFF; ez[4]=0; ep[4]=0;
        ops[5]=3'b000; va[5]=8'h0F; vb[5]=8'hF0; er[5]=8'h00; ez[5]=1; ep[5]=0;
        ops[6]=3'b010; va[6]=8'hF0; vb[6]=8'h3C; er[6]=8'hFC; ez[6]=0; ep[6]=0;
        ops[7]=3'b111; va[7]=8'h01; vb[7]=8'hFF; er[7]=8'h01; ez[7]=0; ep[7]=1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], va[i], vb[i], 1'b0, 1'b0);
            step();
            exp_count = exp_count + 4'd1;
            checks++;
            if (bus.result !== er[i] || bus.zero !== ez[i] || bus.parity !== ep[i] || bus.out_valid !== 1'b1)
            begin
                errors++;
                $display("FAIL op_vec%0d got res=%h z=%b p=%b v=%b exp res=%h z=%b p=%b v=1",
                         i, bus.result, bus.zero, bus.parity, bus.out_valid, er[i], ez[i], ep[i]);
            end
        end
        drive(1'b1, 3'b101, 8'hF0, 8'h3C, 1'b0, 1'b0);
        step();
        exp_count = exp_count + 4'd1;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.result !== 8'h33) begin errors++; $display("FAIL op_xnor got %h exp 33", bus.result); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h33) begin
            errors++; $display("FAIL op_drain got v=%b res=%h exp v=0 res=33", bus.out_valid, bus.result);
        end
        checks++;
        if (bus.count !== exp_count) begin errors++; $display("FAIL op_count got %0d exp %0d", bus.count, exp_count); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b000, 8'hFF, 8'hAA, 1'b0, 1'b0);
        step();
        exp_count = exp_count + 4'd1;
        drive(1'b1, 3'b111, 8'h55, 8'h00, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.result !== 8'hAA) begin
            errors++; $display("FAIL bp_first got rdy=%b res=%h exp rdy=0 res=AA", bus.in_ready, bus.result);
        end
        step();
        checks++;
        if (bus.result !== 8'hAA || bus.out_valid !== 1'b1 || bus.count !== exp_count) begin
            errors++; $display("FAIL bp_hold got res=%h v=%b cnt=%0d exp res=AA v=1 cnt=%0d",
                               bus.result, bus.out_valid, bus.count, exp_count);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b exp 1", bus.in_ready); end
        step();
        exp_count = exp_count + 4'd1;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.result !== 8'h55 || bus.out_valid !== 1'b1 || bus.count !== exp_count) begin
            errors++; $display("FAIL bp_second got res=%h v=%b cnt=%0d exp res=55 v=1 cnt=%0d",
                               bus.result, bus.out_valid, bus.count, exp_count);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_accumulate();
        logic [2:0] ops [4];
        logic [7:0] vb  [4];
        logic [7:0] er  [4];
        ops[0]=3'b010; vb[0]=8'h01; er[0]=8'h01;
        ops[1]=3'b010; vb[1]=8'h02; er[1]=8'h03;
        ops[2]=3'b010; vb[2]=8'h04; er[2]=8'h07;
        ops[3]=3'b100; vb[3]=8'h07; er[3]=8'h00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // Operand a is deliberately junk: acc_mode must ignore it
            drive(1'b1, ops[i], 8'hA5, vb[i], 1'b1, (i == 0));
            step();
            checks++;
            if (bus.result !== er[i]) begin errors++; $display("FAIL acc_vec%0d got %h exp %h", i, bus.result, er[i]); end
        end
        checks++;
        if (bus.zero !== 1'b1) begin errors++; $display("FAIL acc_zero got %b exp 1", bus.zero); end
        drive(1'b1, 3'b010, 8'h00, 8'h3C, 1'b1, 1'b0);
        step();
        // Clear with no accept must still zero the accumulator
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'b111, 8'hFF, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.result !== 8'h00 || bus.zero !== 1'b1) begin
            errors++; $display("FAIL acc_clr_idle got res=%h z=%b exp res=00 z=1", bus.result, bus.zero);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int bad_valid;
        bad_valid = 0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'b111, 8'(i), 8'h00, 1'b0, 1'b0);
            step();
            if (bus.out_valid !== 1'b1) bad_valid++;
        end
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bad_valid != 0) begin errors++; $display("FAIL b2b_valid got %0d gaps exp 0", bad_valid); end
        checks++;
        if (bus.count !== 4'd1) begin errors++; $display("FAIL b2b_count_wrap got %0d exp 1", bus.count); end
        checks++;
        if (bus.result !== 8'h10) begin errors++; $display("FAIL b2b_last got %h exp 10", bus.result); end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111, 8'h5A, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.count !== 4'd0 || bus.parity !== 1'b0) begin
            errors++; $display("FAIL async_rst got v=%b res=%h cnt=%0d p=%b exp v=0 res=00 cnt=0 p=0",
                               bus.out_valid, bus.result, bus.count, bus.parity);
        end
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b111, 8'hFF, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.result !== 8'h00 || bus.count !== 4'd1) begin
            errors++; $display("FAIL async_rst_acc got res=%h cnt=%0d exp res=00 cnt=1", bus.result, bus.count);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = '0;
        test_reset();
        test_ops();
        test_backpressure();
        test_accumulate();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
